// File: rtl/sync_dp_ram_if.sv
// rtl/sync_dp_ram_if.sv - write/read/status bundle for sync_dp_ram
interface sync_dp_ram_if #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 8
);
  logic                   wr_en;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [DATA_SIZE/8-1:0] wr_be;
  logic [DATA_SIZE-1:0]   d_in;
  logic                   rd_en;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic [DATA_SIZE-1:0]   d_out;
  logic                   rd_valid;
  logic                   busy;

  modport master (
    output wr_en, wr_addr, wr_be, d_in, rd_en, rd_addr,
    input  d_out, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, d_in, rd_en, rd_addr,
    output d_out, rd_valid, busy
  );
endinterface

// File: rtl/sync_dp_ram.sv
// rtl/sync_dp_ram.sv - simple dual-port synchronous RAM with byte enables,
// selectable read-during-write, optional output register and post-reset clear engine
module sync_dp_ram #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 8,
  parameter int MEM_SIZE  = 1024,
  parameter int RDW_MODE  = 0,
  parameter int OUT_REG   = 0,
  parameter logic [DATA_SIZE-1:0] CLR_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  sync_dp_ram_if.slave bus
);
  localparam int NBYTES = DATA_SIZE / 8;
  localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_SIZE:0]   ADDR_LIM  = (ADDR_SIZE+1)'(MEM_SIZE);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic                 busy;
  logic                 clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // CLEAR leaves at the same edge that writes the last word
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_SIZE'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic wr_in_range, rd_in_range;
  logic wr_go, rd_go, bypass;

  assign wr_in_range = {1'b0, bus.wr_addr} < ADDR_LIM;
  assign rd_in_range = {1'b0, bus.rd_addr} < ADDR_LIM;
  assign wr_go  = bus.wr_en && !busy && !rst && wr_in_range && (bus.wr_be != '0);
  assign rd_go  = bus.rd_en && !busy && !rst;
  assign bypass = (RDW_MODE != 0) && wr_go && (bus.wr_addr == bus.rd_addr);

  logic [DATA_SIZE-1:0] mem [0:MEM_SIZE-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_cnt_q[MEM_AW-1:0]] <= CLR_VAL;
      end
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_go && bus.wr_be[i]) begin
          mem[bus.wr_addr[MEM_AW-1:0]][8*i +: 8] <= bus.d_in[8*i +: 8];
        end
      end
    end
  end

  // Bypass merges the incoming bytes onto the stored word for new-data reads
  logic [DATA_SIZE-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_addr[MEM_AW-1:0]];
      for (int i = 0; i < NBYTES; i++) begin
        if (bypass && bus.wr_be[i]) begin
          rd_word[8*i +: 8] = bus.d_in[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_SIZE-1:0] s1_data;
  logic                 s1_valid;
  logic [DATA_SIZE-1:0] d_out_q;
  logic                 rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_q <= 1'b0;
          d_out_q    <= '0;
        end else begin
          rd_valid_q <= s1_valid;
          if (s1_valid) begin
            d_out_q <= s1_data;
          end
        end
      end
    end else begin : g_no_out_reg
      assign rd_valid_q = s1_valid;
      assign d_out_q    = s1_data;
    end
  endgenerate

  assign bus.d_out    = d_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_sync_dp_ram.sv
// tb/tb_sync_dp_ram.sv - bench for sync_dp_ram: old-data, new-data and output-register variants
module tb_sync_dp_ram;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int MS = 12;
  localparam logic [15:0] CLR = 16'hA5A5;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] di;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    int          c;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  vec_t        vt[$];
  sb_t         sbq[3][$];
  logic [15:0] model [0:MS-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_dp_ram_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) if0 ();
  sync_dp_ram_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) if1 ();
  sync_dp_ram_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) if2 ();

  sync_dp_ram #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_SIZE(MS), .RDW_MODE(0), .OUT_REG(0), .CLR_VAL(CLR))
    u_old (.clk(clk), .rst(rst), .bus(if0));
  sync_dp_ram #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_SIZE(MS), .RDW_MODE(1), .OUT_REG(0), .CLR_VAL(CLR))
    u_new (.clk(clk), .rst(rst), .bus(if1));
  sync_dp_ram #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_SIZE(MS), .RDW_MODE(0), .OUT_REG(1), .CLR_VAL(CLR))
    u_reg (.clk(clk), .rst(rst), .bus(if2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [1:0] be,
                       input logic [15:0] di, input logic re, input logic [3:0] ra);
    if0.wr_en = we; if0.wr_addr = wa; if0.wr_be = be; if0.d_in = di; if0.rd_en = re; if0.rd_addr = ra;
    if1.wr_en = we; if1.wr_addr = wa; if1.wr_be = be; if1.d_in = di; if1.rd_en = re; if1.rd_addr = ra;
    if2.wr_en = we; if2.wr_addr = wa; if2.wr_be = be; if2.d_in = di; if2.rd_en = re; if2.rd_addr = ra;
  endtask

  task automatic add(input logic we, input logic [3:0] wa, input logic [1:0] be, input logic [15:0] di,
                     input logic re, input logic [3:0] ra, input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.di = di; v.re = re; v.ra = ra; v.e0 = e0; v.e1 = e1;
    vt.push_back(v);
  endtask

  // One request per cycle; expectations are queued with the cycle they must appear in
  task automatic apply(input vec_t v);
    sb_t e;
    @(posedge clk); #1;
    drive(v.we, v.wa, v.be, v.di, v.re, v.ra);
    if (v.re) begin
      e.d = v.e0; e.c = cyc + 1; sbq[0].push_back(e);
      e.d = v.e1; e.c = cyc + 1; sbq[1].push_back(e);
      e.d = v.e0; e.c = cyc + 2; sbq[2].push_back(e);
    end
    if (v.we && v.wa < MS) begin
      for (int b = 0; b < 2; b++) begin
        if (v.be[b]) model[v.wa][8*b +: 8] = v.di[8*b +: 8];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
    end
  endtask

  task automatic read_all();
    vec_t v;
    for (int a = 0; a < MS; a++) begin
      v.we = 1'b0; v.wa = 4'd0; v.be = 2'b00; v.di = 16'h0;
      v.re = 1'b1; v.ra = 4'(a); v.e0 = model[a]; v.e1 = model[a];
      apply(v);
    end
    idle(4);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!if0.busy) break;
      n++;
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [15:0] d);
    sb_t e;
    if (sbq[k].size() > 0 && sbq[k][0].c < cyc) begin
      tests++; fails++;
      e = sbq[k].pop_front();
      $display("FAIL rd_missing u%0d: got no rd_valid at cyc %0d, want %h", k, e.c, e.d);
    end
    if (v) begin
      tests++;
      if (sbq[k].size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected u%0d: got rd_valid d_out=%h at cyc %0d, want none", k, d, cyc);
      end else begin
        e = sbq[k].pop_front();
        if (e.d !== d || e.c != cyc) begin
          fails++;
          $display("FAIL rd_data u%0d: got %h at cyc %0d, want %h at cyc %0d", k, d, cyc, e.d, e.c);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.rd_valid, if0.d_out);
    mon(1, if1.rd_valid, if1.d_out);
    mon(2, if2.rd_valid, if2.d_out);
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
    for (int a = 0; a < MS; a++) model[a] = CLR;

    // wr  addr  be     d_in      rd  addr  old-data  new-data
    add(1, 4'd3,  2'b01, 16'h1234, 0, 4'd0,  16'h0000, 16'h0000);
    add(0, 4'd0,  2'b00, 16'h0000, 1, 4'd3,  16'hA534, 16'hA534);
    add(1, 4'd3,  2'b10, 16'hBEEF, 0, 4'd0,  16'h0000, 16'h0000);
    add(0, 4'd0,  2'b00, 16'h0000, 1, 4'd3,  16'hBE34, 16'hBE34);
    add(1, 4'd5,  2'b11, 16'h0001, 0, 4'd0,  16'h0000, 16'h0000);
    add(1, 4'd5,  2'b11, 16'h00FF, 1, 4'd5,  16'h0001, 16'h00FF);
    add(0, 4'd0,  2'b00, 16'h0000, 1, 4'd5,  16'h00FF, 16'h00FF);
    add(1, 4'd13, 2'b11, 16'hFFFF, 0, 4'd0,  16'h0000, 16'h0000);
    add(0, 4'd0,  2'b00, 16'h0000, 1, 4'd14, 16'h0000, 16'h0000);
    add(1, 4'd7,  2'b00, 16'h1111, 0, 4'd0,  16'h0000, 16'h0000);
    add(0, 4'd0,  2'b00, 16'h0000, 1, 4'd7,  16'hA5A5, 16'hA5A5);
    add(1, 4'd2,  2'b11, 16'hCAFE, 1, 4'd4,  16'hA5A5, 16'hA5A5);
    add(0, 4'd0,  2'b00, 16'h0000, 1, 4'd2,  16'hCAFE, 16'hCAFE);
    add(1, 4'd8,  2'b10, 16'h5A5A, 1, 4'd8,  16'hA5A5, 16'h5AA5);
    add(1, 4'd13, 2'b11, 16'h7777, 1, 4'd13, 16'h0000, 16'h0000);

    // reset held three edges, then the clear must take exactly MEM_SIZE cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(if0.busy), 32'd1);
    check("rst_rd_valid", 32'(if0.rd_valid | if2.rd_valid), 32'd0);
    check("rst_d_out", 32'(if0.d_out | if2.d_out), 32'd0);
    rst = 1'b0;
    count_busy(n);
    check("busy_cycles", 32'(n), 32'd12);
    check("busy_low_reg", 32'(if2.busy), 32'd0);
    read_all();

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);
    idle(4);
    read_all();

    // restart the clear, interrupt it mid-way, and hammer the ports while busy
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2_d_out", 32'(if0.d_out), 32'd0);
    check("rst2_d_out_reg", 32'(if2.d_out), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst3_busy", 32'(if1.busy), 32'd1);
    rst = 1'b0;
    drive(1'b1, 4'd0, 2'b11, 16'h1234, 1'b1, 4'd0);
    count_busy(n);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
    check("busy_cycles_restart", 32'(n), 32'd12);
    for (int a = 0; a < MS; a++) model[a] = CLR;
    read_all();

    for (int k = 0; k < 3; k++) check("scoreboard_empty", 32'(sbq[k].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
